// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counter with one-shot / auto-reload modes and a
// maskable level interrupt; registers are CTRL, PRESET and a read-only COUNT.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic [3:0]  BE,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic ctrl_wr;
    logic preset_wr;
    logic reg_wr;
    logic expire;
    logic auto_reload;

    assign ctrl_wr     = WE && (addr == 2'd0) && BE[0];
    assign preset_wr   = WE && (addr == 2'd1);
    // Any write aimed at CTRL or PRESET acknowledges the interrupt, whatever the byte enables.
    assign reg_wr      = WE && ((addr == 2'd0) || (addr == 2'd1));
    assign expire      = (state == CNT) && en && (count <= 32'd1);
    assign auto_reload = (mode == 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            en      <= 1'b0;
            mode    <= 2'd0;
            im      <= 1'b0;
            preset  <= 32'd0;
            count   <= 32'd0;
            pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en)
                        state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= 32'd0;
                        state <= INT;
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                        en    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // CPU writes come after the FSM so a CTRL write overrides the one-shot Enable clear.
            if (ctrl_wr) begin
                en   <= WD[0];
                mode <= WD[2:1];
                im   <= WD[3];
            end

            for (int i = 0; i < 4; i++) begin
                if (preset_wr && BE[i])
                    preset[8*i +: 8] <= WD[8*i +: 8];
            end

            // Expiry beats a simultaneous acknowledge.
            if (expire)
                pending <= 1'b1;
            else if (reg_wr || ((state == INT) && auto_reload))
                pending <= 1'b0;
        end
    end

    always_comb begin
        RD = 32'd0;
        case (addr)
            2'd0:    RD = {28'd0, im, mode, en};
            2'd1:    RD = preset;
            2'd2:    RD = count;
            default: RD = 32'd0;
        endcase
    end

    assign IRQ = im & pending;

endmodule

// File: tb/tb_timer_counter.sv
// Randomised and directed bench for timer_counter, checked every cycle against
// a behavioural model of the timer's register and countdown rules.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [31:0] WD;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] RD;
    logic        IRQ;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .WD    (WD),
        .WE    (WE),
        .BE    (BE),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_LOAD = 2'd1;
    localparam logic [1:0] PH_RUN  = 2'd2;
    localparam logic [1:0] PH_INT  = 2'd3;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] preset;
        logic [31:0] count;
        logic [1:0]  phase;
        logic        pend;
    } mdl_t;

    mdl_t        mdl;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd_seen [4];
    logic        irq_seen;
    int unsigned exp_os [7] = '{0, 5, 4, 3, 2, 1, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the timer as the programmer sees it.
    function automatic mdl_t model_step(input mdl_t cur, input logic rst, input logic we,
                                        input logic [1:0] a, input logic [31:0] wd,
                                        input logic [3:0] be);
        mdl_t nxt;
        logic enabled;
        logic reloads;
        logic expired;
        nxt = cur;
        if (rst) begin
            nxt = '0;
            return nxt;
        end
        enabled = cur.ctrl[0];
        reloads = (cur.ctrl[2:1] == 2'd1);
        expired = 1'b0;
        if (cur.phase == PH_IDLE && enabled) begin
            nxt.phase = PH_LOAD;
        end else if (cur.phase == PH_LOAD) begin
            nxt.count = cur.preset;
            nxt.phase = PH_RUN;
        end else if (cur.phase == PH_RUN) begin
            if (!enabled)
                nxt.phase = PH_IDLE;
            else if (cur.count >= 2)
                nxt.count = cur.count - 1;
            else begin
                nxt.count = 0;
                nxt.phase = PH_INT;
                expired = 1'b1;
            end
        end else if (cur.phase == PH_INT) begin
            if (reloads) begin
                nxt.phase = PH_LOAD;
                nxt.pend  = 1'b0;
            end else begin
                nxt.phase   = PH_IDLE;
                nxt.ctrl[0] = 1'b0;
            end
        end
        if (we && a == 2'd0) begin
            if (be[0])
                nxt.ctrl = wd[3:0];
            nxt.pend = 1'b0;
        end
        if (we && a == 2'd1) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    nxt.preset[8*i +: 8] = wd[8*i +: 8];
            nxt.pend = 1'b0;
        end
        if (expired)
            nxt.pend = 1'b1;
        return nxt;
    endfunction

    function automatic logic [31:0] model_rd(input mdl_t m, input int a);
        case (a)
            0:       return {28'd0, m.ctrl};
            1:       return m.preset;
            2:       return m.count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick(input logic we, input logic [1:0] a, input logic [31:0] wd,
                        input logic [3:0] be);
        WE   = we;
        addr = a;
        WD   = wd;
        BE   = be;
        @(posedge clk);
        mdl = model_step(mdl, reset, we, a, wd, be);
        #1;
        WE = 1'b0;
        BE = 4'd0;
        for (int k = 0; k < 4; k++) begin
            addr = k[1:0];
            #1;
            rd_seen[k] = RD;
            check($sformatf("rd%0d", k), RD, model_rd(mdl, k));
        end
        irq_seen = IRQ;
        check("irq", {31'd0, IRQ}, {31'd0, mdl.ctrl[3] & mdl.pend});
    endtask

    task automatic idle();
        tick(1'b0, 2'd0, 32'd0, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic flag;
        logic [31:0] rv;
        mdl   = '0;
        reset = 1'b1;
        WE    = 1'b0;
        addr  = 2'd0;
        WD    = 32'd0;
        BE    = 4'd0;

        // Reset with writes attempted
        tick(1'b1, 2'd0, 32'hF, 4'hF);
        tick(1'b1, 2'd1, 32'h55, 4'hF);
        reset = 1'b0;
        check("rst_ctrl", rd_seen[0], 32'd0);
        check("rst_preset", rd_seen[1], 32'd0);
        check("rst_count", rd_seen[2], 32'd0);
        check("rst_irq", {31'd0, irq_seen}, 32'd0);

        // One-shot, PRESET=5
        tick(1'b1, 2'd1, 32'd5, 4'hF);
        tick(1'b1, 2'd0, 32'h9, 4'hF);
        for (int i = 0; i < 7; i++) begin
            idle();
            check($sformatf("os_count%0d", i + 1), rd_seen[2], exp_os[i]);
        end
        check("os_irq_rise", {31'd0, irq_seen}, 32'd1);
        idle();
        check("os_ctrl", rd_seen[0], 32'h8);
        check("os_irq_hold", {31'd0, irq_seen}, 32'd1);
        tick(1'b1, 2'd1, 32'd5, 4'hF);
        check("os_irq_ack", {31'd0, irq_seen}, 32'd0);

        // Auto-reload, PRESET=3
        tick(1'b1, 2'd1, 32'd3, 4'hF);
        tick(1'b1, 2'd0, 32'hB, 4'hF);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (irq_seen)
                pulses++;
        end
        check("ar_pulses", pulses, 32'd4);
        tick(1'b1, 2'd0, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++)
            idle();

        // Masked expiry
        tick(1'b1, 2'd1, 32'd2, 4'hF);
        tick(1'b1, 2'd0, 32'h1, 4'hF);
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle();
            flag = flag | irq_seen;
        end
        check("mask_irq", {31'd0, flag}, 32'd0);
        check("mask_ctrl", rd_seen[0], 32'd0);

        // Byte enables on PRESET
        tick(1'b1, 2'd1, 32'd0, 4'hF);
        tick(1'b1, 2'd1, 32'hAABBCCDD, 4'b0101);
        check("be_preset", rd_seen[1], 32'h00BB00DD);

        // Pause at 7, read-only COUNT, unused address
        tick(1'b1, 2'd1, 32'd20, 4'hF);
        tick(1'b1, 2'd0, 32'h1, 4'hF);
        for (int i = 0; i < 40 && rd_seen[2] != 32'd8; i++)
            idle();
        check("pause_reach8", rd_seen[2], 32'd8);
        tick(1'b1, 2'd0, 32'h0, 4'hF);
        check("pause_count", rd_seen[2], 32'd7);
        for (int i = 0; i < 3; i++)
            idle();
        check("pause_hold", rd_seen[2], 32'd7);
        tick(1'b1, 2'd2, 32'h1234, 4'hF);
        check("count_ro", rd_seen[2], 32'd7);
        tick(1'b1, 2'd3, 32'hFFFFFFFF, 4'hF);
        check("addr3", rd_seen[3], 32'd0);

        // CTRL write on the one-shot INT cycle
        tick(1'b1, 2'd1, 32'd4, 4'hF);
        tick(1'b1, 2'd0, 32'h9, 4'hF);
        for (int i = 0; i < 20 && !irq_seen; i++)
            idle();
        check("col_reach_int", {31'd0, irq_seen}, 32'd1);
        tick(1'b1, 2'd0, 32'h9, 4'hF);
        check("col_ctrl", rd_seen[0], 32'h9);
        check("col_irq", {31'd0, irq_seen}, 32'd0);
        idle();
        idle();
        check("col_restart", rd_seen[2], 32'd4);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            reset = ($urandom_range(0, 149) == 0);
            sel = $urandom_range(0, 11);
            if (sel == 0) begin
                rv = {28'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) != 0)};
                tick(1'b1, 2'd0, rv, 4'($urandom_range(0, 15)));
            end else if (sel == 1) begin
                rv = (($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 9)));
                tick(1'b1, 2'd1, rv, 4'($urandom_range(0, 15)));
            end else if (sel == 2) begin
                tick(1'b1, 2'($urandom_range(2, 3)), $urandom, 4'($urandom_range(0, 15)));
            end else begin
                tick(1'b0, 2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
            end
            if (mdl.preset > 32'd40 && !reset)
                tick(1'b1, 2'd1, 32'd6, 4'hF);
        end
        reset = 1'b0;

        // Reset mid-count
        tick(1'b1, 2'd1, 32'd9, 4'hF);
        tick(1'b1, 2'd0, 32'hB, 4'hF);
        for (int i = 0; i < 5; i++)
            idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check("rst_mid_count", rd_seen[2], 32'd0);
        check("rst_mid_ctrl", rd_seen[0], 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
